// File: rtl/tsu_queue_reader.sv
// Time-stamp queue read side: fetches 92-bit entries into a holding
// register and exposes them to the host as 32-bit words.
module tsu_queue_reader #(
  parameter int CNT_W    = 16,
  parameter int AUTO_POP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       q_rd_stat,
  input  logic [91:0]      q_rd_data,
  output logic             q_rd_en,
  input  logic             host_rd_en,
  input  logic [1:0]       host_addr,
  output logic [31:0]      host_rd_data,
  input  logic             ts_pop,
  output logic             ts_valid,
  output logic [CNT_W-1:0] ts_count
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CAP,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [91:0] hold;
  logic [31:0] rd_word;
  logic [15:0] cnt16;
  logic        avail;
  logic        auto_rd;
  logic        pop;
  logic        ld;
  logic        rel;
  logic        unused_stat;

  assign unused_stat = ^q_rd_stat[7:3];
  assign avail   = q_rd_stat[2:0] != 3'd0;
  assign auto_rd = (AUTO_POP != 0) && host_rd_en
                   && (host_addr == 2'd3);
  assign pop     = ts_pop | auto_rd;

  if (CNT_W >= 16) begin : g_trunc
    assign cnt16 = ts_count[15:0];
  end else begin : g_ext
    assign cnt16 = {{(16-CNT_W){1'b0}}, ts_count};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, one-cycle read request, capture/release strobes
  always_comb begin
    state_nx = state;
    q_rd_en  = 1'b0;
    ld       = 1'b0;
    rel      = 1'b0;
    unique case (state)
      IDLE: begin
        if (avail && !ts_valid && !rst) begin
          q_rd_en  = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        state_nx = CAP;
      end
      CAP: begin
        ld       = 1'b1;
        state_nx = HOLD;
      end
      HOLD: begin
        if (pop) begin
          rel      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Holding register, valid flag and popped-entry counter
  always_ff @(posedge clk) begin
    if (rst) begin
      hold     <= '0;
      ts_valid <= 1'b0;
      ts_count <= '0;
    end else if (ld) begin
      hold     <= q_rd_data;
      ts_valid <= 1'b1;
    end else if (rel) begin
      ts_valid <= 1'b0;
      ts_count <= ts_count + CNT_W'(1);
    end
  end

  // Host word select
  always_comb begin
    rd_word = '0;
    unique case (host_addr)
      2'd0: rd_word = {ts_valid, 12'd0,
                       q_rd_stat[2:0], cnt16};
      2'd1: rd_word = {4'd0, hold[91:64]};
      2'd2: rd_word = hold[63:32];
      2'd3: rd_word = hold[31:0];
      default: rd_word = '0;
    endcase
  end

  // Registered host read data, held between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      host_rd_data <= '0;
    end else if (host_rd_en) begin
      host_rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_tsu_queue_reader.sv
// Scoreboard bench for tsu_queue_reader (CNT_W=4, AUTO_POP=1).
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_tsu_queue_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  q_rd_stat;
  logic [91:0] q_rd_data;
  logic        q_rd_en;
  logic        host_rd_en;
  logic [1:0]  host_addr;
  logic [31:0] host_rd_data;
  logic        ts_pop;
  logic        ts_valid;
  logic [3:0]  ts_count;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } rd_t;

  typedef struct {
    int          sig;
    logic [31:0] exp;
    string       name;
  } chk_t;

  rd_t  rd_q[$];
  chk_t chk_q[$];
  int   tests = 0;
  int   fails = 0;
  int   en_cnt = 0;
  int   idx = 0;
  logic rd_pend = 1'b0;
  logic en_prev = 1'b0;

  always #5 clk = ~clk;

  tsu_queue_reader #(
    .CNT_W(4),
    .AUTO_POP(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .q_rd_stat(q_rd_stat),
    .q_rd_data(q_rd_data),
    .q_rd_en(q_rd_en),
    .host_rd_en(host_rd_en),
    .host_addr(host_addr),
    .host_rd_data(host_rd_data),
    .ts_pop(ts_pop),
    .ts_valid(ts_valid),
    .ts_count(ts_count)
  );

  function automatic logic [91:0] ent(int i);
    case (i)
      0: ent = 92'hA_BCDE_F012_3456_789A_BCDE;
      1: ent = 92'hFED_CBA9_8765_4321_0F1E_2D3C;
      2: ent = 92'h123_4567_89AB_CDEF_0011_2233;
      default: ent = {28'h5A5A5A5, 32'hC0DE_0000, 32'(i)};
    endcase
  endfunction

  // Queue model: registered read data one cycle after q_rd_en
  always @(posedge clk) begin
    if (q_rd_en) begin
      q_rd_data <= ent(idx);
      idx <= idx + 1;
    end
  end

  always @(posedge clk) begin
    rd_pend <= host_rd_en;
    en_prev <= q_rd_en;
    if (q_rd_en) en_cnt <= en_cnt + 1;
  end

  task cmp(input string n, input logic [31:0] got,
           input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  // Monitor: host reads, queued checks, request protocol
  always @(negedge clk) begin
    rd_t  r;
    chk_t c;
    logic [31:0] v;
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_extra: got %h want none", host_rd_data);
      end else begin
        r = rd_q.pop_front();
        cmp(r.name, host_rd_data, r.exp);
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.sig)
        0: v = {31'd0, q_rd_en};
        1: v = {31'd0, ts_valid};
        2: v = {28'd0, ts_count};
        3: v = en_cnt;
        default: v = host_rd_data;
      endcase
      cmp(c.name, v, c.exp);
    end
    if (q_rd_en && q_rd_stat[2:0] == 3'd0) begin
      tests++;
      fails++;
      $display("FAIL en_no_stat: got 1 want 0");
    end
    if (q_rd_en && en_prev) begin
      tests++;
      fails++;
      $display("FAIL en_pulse: got 2-cycle want 1-cycle");
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int s, input logic [31:0] e,
                     input string n);
    chk_t c;
    c.sig = s;
    c.exp = e;
    c.name = n;
    chk_q.push_back(c);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e,
                    input string n);
    rd_t r;
    r.exp = e;
    r.name = n;
    rd_q.push_back(r);
    host_rd_en = 1'b1;
    host_addr = a;
    step(1);
    host_rd_en = 1'b0;
  endtask

  task automatic fetch();
    q_rd_stat = 8'd1;
    step(1);
    q_rd_stat = 8'd0;
    step(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    q_rd_stat = 8'd0;
    host_rd_en = 1'b0;
    host_addr = 2'd0;
    ts_pop = 1'b0;
    step(2);
    chk(0, 0, "rst_en");
    chk(1, 0, "rst_valid");
    chk(2, 0, "rst_count");
    chk(4, 0, "rst_rdata");
    rst = 1'b0;
    step(50);
    chk(3, 0, "idle_no_en");
    rd(2'd0, 32'h0, "idle_addr0");

    q_rd_stat = 8'd1;
    chk(0, 1, "f1_en");
    step(1);
    q_rd_stat = 8'd0;
    chk(0, 0, "f1_en_req");
    chk(1, 0, "f1_valid_req");
    step(1);
    chk(1, 0, "f1_valid_cap");
    step(1);
    chk(1, 1, "f1_valid_hold");
    chk(3, 1, "f1_en_cnt");
    rd(2'd1, 32'h000A_BCDE, "f1_addr1");
    rd(2'd2, 32'hF012_3456, "f1_addr2");
    rd(2'd0, 32'h8000_0000, "f1_addr0");
    ts_pop = 1'b1;
    step(1);
    ts_pop = 1'b0;
    chk(1, 0, "f1_pop_valid");
    chk(2, 1, "f1_pop_count");
    rd(2'd1, 32'h000A_BCDE, "f1_hold_kept");
    rd(2'd0, 32'h0000_0001, "f1_addr0_pop");

    q_rd_stat = 8'd3;
    step(100);
    chk(3, 2, "bp_one_en");
    chk(1, 1, "bp_valid");
    rd(2'd0, 32'h8003_0001, "bp_addr0");
    rd(2'd1, 32'h0FED_CBA9, "bp_addr1");
    ts_pop = 1'b1;
    step(1);
    ts_pop = 1'b0;
    chk(0, 1, "bp_en_after_pop");
    chk(2, 2, "bp_count");
    step(1);
    q_rd_stat = 8'd0;

    ts_pop = 1'b1;
    step(2);
    ts_pop = 1'b0;
    chk(2, 2, "ign_req_cap_count");
    chk(1, 1, "ign_cap_valid");
    rd(2'd2, 32'h89AB_CDEF, "ign_cap_data");
    ts_pop = 1'b1;
    step(1);
    ts_pop = 1'b0;
    chk(2, 3, "ign_hold_pop");
    ts_pop = 1'b1;
    step(2);
    ts_pop = 1'b0;
    chk(2, 3, "ign_idle_count");
    chk(1, 0, "ign_idle_valid");

    fetch();
    rd(2'd3, 32'h0000_0003, "ap_addr3");
    chk(1, 0, "ap_valid");
    chk(2, 4, "ap_count");
    chk(3, 4, "ap_en_cnt");
    fetch();
    ts_pop = 1'b1;
    rd(2'd3, 32'h0000_0004, "ap2_addr3");
    ts_pop = 1'b0;
    chk(2, 5, "ap2_count_once");
    chk(1, 0, "ap2_valid");

    for (int i = 0; i < 11; i++) begin
      fetch();
      ts_pop = 1'b1;
      step(1);
      ts_pop = 1'b0;
      if (i == 9) begin
        chk(2, 15, "wrap_count_f");
        rd(2'd0, 32'h0000_000F, "wrap_addr0_f");
      end
    end
    chk(2, 0, "wrap_count_0");
    rd(2'd0, 32'h0000_0000, "wrap_addr0_0");

    q_rd_stat = 8'd1;
    step(1);
    rst = 1'b1;
    step(1);
    chk(0, 0, "mr_en_in_rst");
    chk(1, 0, "mr_valid");
    chk(2, 0, "mr_count");
    chk(4, 0, "mr_rdata");
    step(2);
    chk(3, 17, "mr_no_en_rst");
    rst = 1'b0;
    q_rd_stat = 8'd0;
    rd(2'd1, 32'h0, "mr_hold_clr");
    rd(2'd3, 32'h0, "mr_idle_addr3");
    chk(2, 0, "mr_idle_ap_count");
    q_rd_stat = 8'd1;
    chk(0, 1, "mr_en_release");
    step(1);
    q_rd_stat = 8'd0;
    step(2);
    chk(1, 1, "mr_valid_new");
    rd(2'd2, 32'hC0DE_0000, "mr_addr2");
    rd(2'd3, 32'h0000_0011, "mr_addr3");
    chk(2, 1, "mr_count_new");
    chk(3, 18, "mr_en_total");
    step(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
